// File: rtl/systolic_drain_ctrl.sv
// Drain sequencer: reads the N x N accumulators row by row, writes them one element
// per cycle to the output RAM, then clears them. Optional ReLU: define DRAIN_RELU_EN.
module systolic_drain_ctrl #(
   parameter int N       = 8,
   parameter int DW      = 32,
   parameter int OADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [OADDR_W-1:0]    base_addr,
   output logic                  busy,
   output logic                  done,
   output logic [$clog2(N)-1:0]  row_sel,
   input  logic [N*DW-1:0]       acc_row,
   input  logic                  ram_o_ready,
   output logic                  ram_o_wren,
   output logic [OADDR_W-1:0]    ram_o_addr,
   output logic [DW-1:0]         ram_o_data,
   output logic [N*N-1:0]        clr_accum
);

   localparam int RW = $clog2(N);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_CLEAR = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [RW-1:0]       r_q, r_d;
   logic [RW-1:0]       c_q, c_d;
   logic [RW-1:0]       rsel_q, rsel_d;
   logic [OADDR_W-1:0]  base_q, base_d;
   logic [N*DW-1:0]     rowbuf_q, rowbuf_d;

   logic [DW-1:0]       elem;
   logic [DW-1:0]       elem_out;
   logic [OADDR_W-1:0]  lin_idx;

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      c_d      = c_q;
      rsel_d   = rsel_q;
      base_d   = base_q;
      rowbuf_d = rowbuf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               r_d     = '0;
               c_d     = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            rowbuf_d = acc_row;
            rsel_d   = r_q;
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            // A stalled RAM port freezes the whole sequence.
            if (ram_o_ready) begin
               if (c_q == RW'(N - 1)) begin
                  c_d = '0;
                  if (r_q == RW'(N - 1)) begin
                     r_d     = '0;
                     state_d = S_CLEAR;
                  end else begin
                     r_d     = r_q + 1'b1;
                     state_d = S_FETCH;
                  end
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end
         S_CLEAR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         r_q      <= '0;
         c_q      <= '0;
         rsel_q   <= '0;
         base_q   <= '0;
         rowbuf_q <= '0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         c_q      <= c_d;
         rsel_q   <= rsel_d;
         base_q   <= base_d;
         rowbuf_q <= rowbuf_d;
      end
   end

   always_comb begin
      elem    = rowbuf_q[int'(c_q)*DW +: DW];
      lin_idx = OADDR_W'(int'(r_q) * N + int'(c_q));
`ifdef DRAIN_RELU_EN
      elem_out = elem[DW-1] ? '0 : elem;
`else
      elem_out = elem;
`endif
   end

   // row_sel follows r only while fetching so the row mux sees a live select in FETCH.
   assign row_sel    = (state_q == S_FETCH) ? r_q : rsel_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_CLEAR);
   assign clr_accum  = {(N*N){done}};
   assign ram_o_wren = (state_q == S_WRITE) && ram_o_ready;
   assign ram_o_addr = (state_q == S_WRITE) ? (base_q + lin_idx) : '0;
   assign ram_o_data = (state_q == S_WRITE) ? elem_out : '0;

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Bench for systolic_drain_ctrl (N=4): a slot-schedule reference model predicts every
// cycle's outputs; a write queue holds the expected (address, data) sequence.
module tb_systolic_drain_ctrl;

   localparam int N       = 4;
   localparam int DW      = 32;
   localparam int OADDR_W = 8;
   localparam int LAST    = N * (N + 1);
   localparam int BOUND   = 400;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [OADDR_W-1:0]    base_addr;
   logic                  busy;
   logic                  done;
   logic [$clog2(N)-1:0]  row_sel;
   logic [N*DW-1:0]       acc_row;
   logic                  ram_o_ready;
   logic                  ram_o_wren;
   logic [OADDR_W-1:0]    ram_o_addr;
   logic [DW-1:0]         ram_o_data;
   logic [N*N-1:0]        clr_accum;

   logic [DW-1:0]         pe [N][N];
   logic [OADDR_W-1:0]    exp_addr_q[$];
   logic [DW-1:0]         exp_data_q[$];

   int checks = 0;
   int errors = 0;
   int last_done_cyc;

   systolic_drain_ctrl #(.N(N), .DW(DW), .OADDR_W(OADDR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .busy        (busy),
      .done        (done),
      .row_sel     (row_sel),
      .acc_row     (acc_row),
      .ram_o_ready (ram_o_ready),
      .ram_o_wren  (ram_o_wren),
      .ram_o_addr  (ram_o_addr),
      .ram_o_data  (ram_o_data),
      .clr_accum   (clr_accum)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int c = 0; c < N; c++) acc_row[c*DW +: DW] = pe[row_sel][c];
   end

   function automatic logic [DW-1:0] model_elem(input logic [DW-1:0] v);
`ifdef DRAIN_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic fill_index();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) pe[r][c] = DW'(r * N + c);
   endtask

   task automatic fill_random();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) pe[r][c] = $urandom;
   endtask

   // Slot p of a drain: row p/(N+1); offset 0 is the fetch, offsets 1..N write columns
   // 0..N-1; slot LAST is the clear. Only a write slot with ready low fails to advance.
   task automatic run_drain(input logic [OADDR_W-1:0] base, input int stall_idx,
                            input int stall_len, input int rand_pct,
                            input int start_cyc, input int rst_cyc);
      int p, cyc, stall_left, stalls, writes, wr_idx, row, off;
      logic is_write, finished, aborted;
      exp_addr_q.delete();
      exp_data_q.delete();
      for (int i = 0; i < N * N; i++) begin
         exp_addr_q.push_back(base + OADDR_W'(i));
         exp_data_q.push_back(model_elem(pe[i / N][i % N]));
      end
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = base;
      ram_o_ready = 1'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      p = 0; cyc = 1; stall_left = stall_len; stalls = 0; writes = 0;
      finished = 1'b0; aborted = 1'b0; last_done_cyc = -1;
      while (!finished && cyc < BOUND) begin
         row = p / (N + 1);
         off = p % (N + 1);
         is_write = (p < LAST) && (off != 0);
         wr_idx = row * N + off - 1;
         base_addr = OADDR_W'($urandom);
         ram_o_ready = 1'b1;
         if (rand_pct > 0 && $urandom_range(0, 99) < rand_pct) ram_o_ready = 1'b0;
         if (is_write && wr_idx == stall_idx && stall_left > 0) begin
            ram_o_ready = 1'b0;
            stall_left--;
         end
         start = (cyc == start_cyc);
         rst = (cyc == rst_cyc);
         @(negedge clk);
         checks++;
         if (busy !== 1'b1) begin
            errors++; $display("FAIL busy cyc %0d: got %b expected 1", cyc, busy);
         end
         checks++;
         if (done !== (p == LAST)) begin
            errors++; $display("FAIL done cyc %0d: got %b expected %b", cyc, done, p == LAST);
         end
         checks++;
         if (clr_accum !== ((p == LAST) ? {(N*N){1'b1}} : {(N*N){1'b0}})) begin
            errors++; $display("FAIL clr_accum cyc %0d: got %h", cyc, clr_accum);
         end
         checks++;
         if (ram_o_wren !== (is_write && ram_o_ready)) begin
            errors++; $display("FAIL wren cyc %0d: got %b expected %b", cyc, ram_o_wren,
                               is_write && ram_o_ready);
         end
         if (p < LAST && off == 0) begin
            checks++;
            if (int'(row_sel) !== row) begin
               errors++; $display("FAIL row_sel cyc %0d: got %0d expected %0d", cyc, row_sel, row);
            end
         end
         if (is_write) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
               errors++; $display("FAIL write_queue cyc %0d: no write expected", cyc);
            end else if (ram_o_addr !== exp_addr_q[0] || ram_o_data !== exp_data_q[0]) begin
               errors++;
               $display("FAIL write cyc %0d: got addr %h data %h expected addr %h data %h",
                        cyc, ram_o_addr, ram_o_data, exp_addr_q[0], exp_data_q[0]);
            end
         end
         if (p == LAST) last_done_cyc = cyc;
         if (cyc == rst_cyc) begin
            @(posedge clk); #1;
            rst = 1'b0;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy, done, ram_o_wren, row_sel, ram_o_addr, ram_o_data, clr_accum} !== '0) begin
               errors++;
               $display("FAIL reset_outputs: got busy %b done %b wren %b row_sel %0d addr %h data %h clr %h expected all 0",
                        busy, done, ram_o_wren, row_sel, ram_o_addr, ram_o_data, clr_accum);
            end
            aborted = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (is_write && ram_o_ready) begin
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
            writes++;
         end
         if (is_write && !ram_o_ready) stalls++;
         else p++;
         if (p > LAST) finished = 1'b1;
         cyc++;
      end
      start = 1'b0;
      rst = 1'b0;
      ram_o_ready = 1'b1;
      if (aborted) begin
         @(posedge clk); #1;
      end else if (!finished) begin
         checks++; errors++;
         $display("FAIL drain_timeout: no CLEAR within %0d cycles", BOUND);
      end else begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || clr_accum !== '0) begin
            errors++; $display("FAIL post_drain cyc %0d: got busy %b done %b expected 0 0", cyc, busy, done);
         end
         checks++;
         if (writes !== N * N || exp_addr_q.size() !== 0) begin
            errors++; $display("FAIL write_count: got %0d expected %0d", writes, N * N);
         end
         checks++;
         if (last_done_cyc !== LAST + 1 + stalls) begin
            errors++; $display("FAIL done_cycle: got %0d expected %0d", last_done_cyc, LAST + 1 + stalls);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, ram_o_wren, row_sel, ram_o_addr, ram_o_data, clr_accum} !== '0) begin
         errors++; $display("FAIL reset_state: got busy %b done %b wren %b addr %h data %h clr %h expected all 0",
                            busy, done, ram_o_wren, ram_o_addr, ram_o_data, clr_accum);
      end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL start_with_reset: got busy %b expected 0", busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      fill_index();
      run_drain(8'h10, -1, 0, 0, -1, -1);
      checks++;
      if (last_done_cyc !== 21) begin
         errors++; $display("FAIL basic_done_cycle: got %0d expected 21", last_done_cyc);
      end
   endtask

   task automatic test_backpressure();
      fill_index();
      run_drain(8'h10, 6, 3, 0, -1, -1);
      checks++;
      if (last_done_cyc !== 24) begin
         errors++; $display("FAIL backpressure_done_cycle: got %0d expected 24", last_done_cyc);
      end
   endtask

   task automatic test_wrap();
      fill_random();
      run_drain(8'hF8, -1, 0, 0, -1, -1);
   endtask

   task automatic test_reset_mid();
      fill_random();
      run_drain(8'h20, -1, 0, 0, -1, 10);
      fill_random();
      run_drain(8'h40, -1, 0, 0, -1, -1);
   endtask

   task automatic test_start_ignored();
      fill_random();
      run_drain(8'h33, -1, 0, 0, 5, -1);
   endtask

   task automatic test_relu();
      fill_index();
      pe[0][0] = 32'hFFFF_FFFB;
      pe[0][1] = 32'd7;
      pe[2][3] = 32'h8000_0000;
      run_drain(8'h00, -1, 0, 0, -1, -1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         fill_random();
         run_drain(OADDR_W'($urandom), $urandom_range(0, N * N - 1), $urandom_range(0, 4),
                   $urandom_range(0, 40), $urandom_range(2, 20), -1);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      ram_o_ready = 1'b1;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) pe[r][c] = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_start_ignored();
      test_relu();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_drain_ctrl.md
# systolic_drain_ctrl

Drain sequencer for the N×N systolic MAC array. After a compute pass, it reads the accumulators out one row at a time and serialises them, one element per cycle, into the output RAM write port. When the last element is written it clears every accumulator in a single cycle. It sits beside the array controller, which pulses `start` once the compute pass has finished. It owns the output-RAM write port and the accumulator clear lines during a drain.

## Interface
- `N`, default 8: array dimension (rows = columns).
- `DW`, default 32: accumulator / output element width.
- `OADDR_W`, default 8: output RAM address width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle pulse; begins a drain.
- `base_addr`  in  OADDR_W  output RAM base address; sampled on the accepted `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the CLEAR cycle.
- `done`  out  1  one-cycle pulse, coincident with CLEAR.
- `row_sel`  out  $clog2(N)  accumulator row select into the datapath row mux.
- `acc_row`  in  N*DW  selected row, combinational from `row_sel`; element c is `[c*DW +: DW]`.
- `ram_o_ready`  in  1  output RAM write port available; low means stall.
- `ram_o_wren`  out  1  output RAM write enable.
- `ram_o_addr`  out  OADDR_W  output RAM write address.
- `ram_o_data`  out  DW  output RAM write data.
- `clr_accum`  out  N*N  per-PE accumulator clear; bit r*N+c corresponds to PE[r][c].

## Operation
- FSM states: IDLE, FETCH, WRITE, CLEAR.
- IDLE:
  - `start`=1 latches `base_addr` and resets the row counter r and column counter c to 0.
  - Next state is FETCH.
- FETCH, one cycle:
  - `row_sel`=r.
  - `acc_row` is captured into an internal N*DW row buffer at the end of the cycle.
  - Next state is WRITE.
- WRITE:
  - `ram_o_wren` = `ram_o_ready` (combinational).
  - `ram_o_data` = row buffer element c.
  - `ram_o_addr` = (base + r*N + c) mod 2^OADDR_W. Wrap-around is silent truncation.
  - With `ram_o_ready`=1, c increments each cycle.
  - With `ram_o_ready`=0, c, r and the state hold, and no write occurs.
  - After c=N-1 is written: if r<N-1, r increments, c goes to 0, and next state is FETCH. If r=N-1, next state is CLEAR.
- CLEAR, one cycle:
  - `clr_accum` is all ones and `done`=1.
  - Next state is IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor used to restart.
- `start` in the same cycle as `rst`: reset wins.
- `rst` mid-drain:
  - Next state is IDLE, counters return to 0, and the row buffer is don't-care.
  - No CLEAR or `done` pulse is issued. Partially written RAM contents are left as they are.
- `row_sel` outside FETCH holds its last value. The datapath must not rely on it outside FETCH.

## Timing
- Reset values: `busy`, `done`, `row_sel`, `ram_o_wren`, `ram_o_addr`, `ram_o_data` and `clr_accum` are all 0; state is IDLE.
- Cycle numbering: `start` is sampled at the edge ending cycle 0. FETCH of row 0 is cycle 1.
- With `ram_o_ready` held high:
  - Each row takes 1+N cycles.
  - CLEAR is at cycle N*(N+1)+1; for N=8 that is cycle 73.
  - `busy` falls, and a new `start` can be accepted, at cycle N*(N+1)+2.
- Each cycle of `ram_o_ready`=0 in WRITE adds exactly one cycle. `ready` in FETCH or CLEAR has no effect.
- Between `row_sel` and sampling there is a combinational path to `acc_row` within the FETCH cycle.
- `ram_o_wren` is combinational from `ram_o_ready`. `ram_o_addr` and `ram_o_data` are valid whenever the state is WRITE.

## Configuration
- `DRAIN_RELU_EN`:
  - Defined: each element is passed through ReLU before it is written. A negative two's-complement value (MSB=1) is written as 0.
  - Undefined: elements are written unmodified.
- Cycle timing is identical in both builds.

## Test plan
- Basic drain, N=4, base 0x10, `ready`=1, PE[r][c]=r*4+c:
  - Writes at 0x10..0x1F carry data 0..15 in order.
  - `done` and all-ones `clr_accum` at cycle 21; `busy` low at cycle 22.
- Backpressure, N=4, `ready` low for 3 cycles during the write of row 1 col 2:
  - No write while `ready` is low and address 0x16 is held.
  - Total drain lengthens by 3 cycles; write order is unchanged.
- Wrap, N=4, base 0xF8, OADDR_W=8: writes land at 0xF8..0xFF, then 0x00..0x07.
- Reset at cycle 10 mid-drain:
  - All outputs are 0 next cycle and `clr_accum` is never asserted.
  - A fresh `start` afterwards drains correctly from row 0.
- `start` pulsed at cycle 5 during a drain: ignored, and exactly N*N writes and one `done` occur.
- `DRAIN_RELU_EN` with PE[0][0]=-5 and PE[0][1]=7:
  - Defined: writes 0 and 7.
  - Undefined: writes 0xFFFFFFFB and 7.
